// File: rtl/mem_arb.sv
// mem_arb: arbitrates the IFU and LSU onto the single shared memory port.
// Each access is serialised as IDLE -> ACCESS -> RESP. Illegal requests
// (misaligned address, or an LSU mask that is not one-hot) skip ACCESS and
// return an error response one cycle after the handshake.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ifu_req_*/ifu_resp_* instruction fetch request/response (32-bit word reads)
//   lsu_req_*/lsu_resp_* load/store request/response (mask: b0 dword, b1 word,
//                        b2 half, b3 byte; load data is right-justified)
//   mem_*               memory port; rdata is combinational, writes commit on
//                       the posedge that ends ACCESS
//
// Build option: define MEM_ARB_RR_EN for strict round-robin arbitration.
// Without it, the LSU has priority and the IFU is forced through after
// STARVE_LIM consecutive LSU grants taken while the IFU was waiting.
module mem_arb #(
  parameter int unsigned AW         = 64,
  parameter int unsigned DW         = 64,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ifu_req_valid,
  output logic          ifu_req_ready,
  input  logic [AW-1:0] ifu_addr,
  output logic          ifu_resp_valid,
  output logic          ifu_resp_err,
  output logic [31:0]   ifu_rdata,
  input  logic          lsu_req_valid,
  output logic          lsu_req_ready,
  input  logic          lsu_wen,
  input  logic [3:0]    lsu_mask,
  input  logic [AW-1:0] lsu_addr,
  input  logic [DW-1:0] lsu_wdata,
  output logic          lsu_resp_valid,
  output logic          lsu_resp_err,
  output logic [DW-1:0] lsu_rdata,
  output logic          mem_ena,
  output logic          mem_wen,
  output logic [3:0]    mem_mask,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wen_q, wen_d;
  logic [3:0]    mask_q, mask_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          owner_q, owner_d;   // 1 = LSU owns the current access
  logic          err_q, err_d;
  logic [31:0]   ifu_rdata_q, ifu_rdata_d;
  logic [DW-1:0] lsu_rdata_q, lsu_rdata_d;

  logic ifu_win, lsu_win, ifu_hs, lsu_hs, ifu_bad, lsu_bad;

`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;              // 1 = LSU was granted last
`else
  logic [3:0] cnt_q, cnt_d;
`endif

  // Winner selection
  always_comb begin
`ifdef MEM_ARB_RR_EN
    if (ifu_req_valid && lsu_req_valid) lsu_win = !last_q;
    else                                lsu_win = lsu_req_valid;
`else
    lsu_win = lsu_req_valid && !(ifu_req_valid && (cnt_q == 4'(STARVE_LIM)));
`endif
    ifu_win = ifu_req_valid && !lsu_win;
  end

  assign ifu_hs = (state_q == IDLE) && ifu_win;
  assign lsu_hs = (state_q == IDLE) && lsu_win;

  // Legality of the incoming request, evaluated at latch time
  always_comb begin
    ifu_bad = (ifu_addr[1:0] != 2'b00);
    unique case (lsu_mask)
      4'b0001: lsu_bad = (lsu_addr[2:0] != 3'b000);
      4'b0010: lsu_bad = (lsu_addr[1:0] != 2'b00);
      4'b0100: lsu_bad = lsu_addr[0];
      4'b1000: lsu_bad = 1'b0;
      default: lsu_bad = 1'b1;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (lsu_hs)      state_d = lsu_bad ? RESP : ACCESS;
        else if (ifu_hs) state_d = ifu_bad ? RESP : ACCESS;
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, read capture and arbitration bookkeeping
  always_comb begin
    addr_d      = addr_q;
    wen_d       = wen_q;
    mask_d      = mask_q;
    wdata_d     = wdata_q;
    owner_d     = owner_q;
    err_d       = err_q;
    ifu_rdata_d = ifu_rdata_q;
    lsu_rdata_d = lsu_rdata_q;
    if (lsu_hs) begin
      addr_d      = lsu_addr;
      wen_d       = lsu_wen;
      mask_d      = lsu_mask;
      wdata_d     = lsu_wdata;
      owner_d     = 1'b1;
      err_d       = lsu_bad;
      lsu_rdata_d = '0;              // stores and errors return zero data
    end else if (ifu_hs) begin
      addr_d      = ifu_addr;
      wen_d       = 1'b0;
      mask_d      = 4'b0010;
      wdata_d     = '0;
      owner_d     = 1'b0;
      err_d       = ifu_bad;
      ifu_rdata_d = '0;
    end
    if (state_q == ACCESS && !wen_q) begin
      if (owner_q) lsu_rdata_d = mem_rdata;
      else         ifu_rdata_d = mem_rdata[31:0];
    end
  end

`ifdef MEM_ARB_RR_EN
  always_comb begin
    last_d = last_q;
    if (lsu_hs)      last_d = 1'b1;
    else if (ifu_hs) last_d = 1'b0;
  end
`else
  // Counts LSU grants taken while the IFU is kept waiting; any gap in
  // ifu_req_valid restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    if (!ifu_req_valid || ifu_hs)        cnt_d = '0;
    else if (lsu_hs && cnt_q != 4'hF)    cnt_d = cnt_q + 4'd1;
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      mask_q      <= '0;
      wdata_q     <= '0;
      owner_q     <= 1'b0;
      err_q       <= 1'b0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_q      <= 1'b0;
`else
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      mask_q      <= mask_d;
      wdata_q     <= wdata_d;
      owner_q     <= owner_d;
      err_q       <= err_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_q      <= last_d;
`else
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Outputs: memory port is decoded from the state register so that reset
  // drops mem_ena immediately and no write can commit.
  always_comb begin
    mem_ena   = 1'b0;
    mem_wen   = 1'b0;
    mem_mask  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ACCESS) begin
      mem_ena   = 1'b1;
      mem_wen   = wen_q;
      mem_mask  = mask_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
    end
    ifu_req_ready  = ifu_hs;
    lsu_req_ready  = lsu_hs;
    ifu_resp_valid = (state_q == RESP) && !owner_q;
    lsu_resp_valid = (state_q == RESP) && owner_q;
    ifu_resp_err   = ifu_resp_valid && err_q;
    lsu_resp_err   = lsu_resp_valid && err_q;
    ifu_rdata      = ifu_rdata_q;
    lsu_rdata      = lsu_rdata_q;
  end

endmodule

// File: tb/tb_mem_arb.sv
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready;
  logic [63:0] ifu_addr;
  logic        ifu_resp_valid, ifu_resp_err;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen;
  logic [3:0]  lsu_mask;
  logic [63:0] lsu_addr, lsu_wdata;
  logic        lsu_resp_valid, lsu_resp_err;
  logic [63:0] lsu_rdata;
  logic        mem_ena, mem_wen;
  logic [3:0]  mem_mask;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  mem_arb #(.AW(64), .DW(64), .STARVE_LIM(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_err(ifu_resp_err), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
    .lsu_mask(lsu_mask), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_err(lsu_resp_err), .lsu_rdata(lsu_rdata),
    .mem_ena(mem_ena), .mem_wen(mem_wen), .mem_mask(mem_mask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Background content of every byte that has never been written
  function automatic logic [7:0] pat(input logic [7:0] a);
    return 8'(a * 8'd37 + 8'h5C);
  endfunction

  function automatic int size_of(input logic [3:0] m);
    case (m)
      4'b0001: return 8;
      4'b0010: return 4;
      4'b0100: return 2;
      4'b1000: return 1;
      default: return 0;
    endcase
  endfunction

  // Memory device (256 bytes mirrored over the address space)
  bit [7:0] dev_mem [256];

  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < 8; i++)
      if (i < size_of(mem_mask))
        mem_rdata[8*i +: 8] = dev_mem[8'(mem_addr[7:0] + 8'(i))] ^ pat(8'(mem_addr[7:0] + 8'(i)));
  end

  always @(posedge clk)
    if (mem_ena && mem_wen)
      for (int i = 0; i < 8; i++)
        if (i < size_of(mem_mask))
          dev_mem[8'(mem_addr[7:0] + 8'(i))] <= mem_wdata[8*i +: 8] ^ pat(8'(mem_addr[7:0] + 8'(i)));

  // Reference memory, updated only when a legal store completes
  bit [7:0] model_mem [256];

  function automatic logic [63:0] model_rd(input logic [63:0] addr, input int sz);
    logic [63:0] v = '0;
    for (int i = 0; i < sz; i++)
      v[8*i +: 8] = model_mem[8'(addr[7:0] + 8'(i))] ^ pat(8'(addr[7:0] + 8'(i)));
    return v;
  endfunction

  typedef struct {
    bit          is_lsu;
    bit          err;
    logic [63:0] rdata;
    logic [63:0] addr;
    logic [3:0]  mask;
    bit          wen;
    logic [63:0] wdata;
    int          hs_cyc;
  } exp_t;

  exp_t sb[$];
  bit   grant_log[$];   // 1 = LSU
  int   cyc = 0;
  int   ena_cnt = 0;

  task automatic lsu_op(input bit wen, input logic [3:0] mask, input logic [63:0] addr,
                        input logic [63:0] wdata);
    bit got = 0;
    lsu_req_valid = 1'b1; lsu_wen = wen; lsu_mask = mask; lsu_addr = addr; lsu_wdata = wdata;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (lsu_req_ready) begin got = 1; break; end
    end
    if (!got) check("lsu_hs_timeout", 0, 1);
    @(posedge clk); #1;
    lsu_req_valid = 1'b0;
  endtask

  task automatic ifu_op(input logic [63:0] addr);
    bit got = 0;
    ifu_req_valid = 1'b1; ifu_addr = addr;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ifu_req_ready) begin got = 1; break; end
    end
    if (!got) check("ifu_hs_timeout", 0, 1);
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    check("drain", 64'(sb.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_mem_ena"}, mem_ena, 0);
    check({tag, "_mem_wen"}, mem_wen, 0);
    check({tag, "_mem_mask"}, mem_mask, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_resp_valid"}, {ifu_resp_valid, lsu_resp_valid}, 0);
    check({tag, "_resp_err"}, {ifu_resp_err, lsu_resp_err}, 0);
  endtask

  logic [9:0] exp_order;

  initial begin
    rst_n = 1'b1;
    ifu_req_valid = 0; ifu_addr = '0;
    lsu_req_valid = 0; lsu_wen = 0; lsu_mask = '0; lsu_addr = '0; lsu_wdata = '0;
    fork
      begin : monitor
        exp_t e, n;
        int sz;
        forever begin
          @(negedge clk);
          cyc++;
          if (!rst_n) begin
            sb.delete();
            ena_cnt = 0;
            continue;
          end
          if (mem_ena) begin
            if (sb.size() == 0) check("mem_ena_spurious", 1, 0);
            else begin
              check("ena_cycle", 64'(cyc), 64'(sb[0].hs_cyc + 1));
              check("mem_addr", mem_addr, sb[0].addr);
              check("mem_mask", mem_mask, sb[0].mask);
              check("mem_wen", mem_wen, sb[0].wen);
              if (sb[0].wen) check("mem_wdata", mem_wdata, sb[0].wdata);
            end
            ena_cnt++;
          end
          if (ifu_resp_valid || lsu_resp_valid) begin
            check("resp_both", ifu_resp_valid && lsu_resp_valid, 0);
            if (sb.size() == 0) check("resp_spurious", 1, 0);
            else begin
              e = sb.pop_front();
              check("resp_owner", lsu_resp_valid, e.is_lsu);
              check("resp_latency", 64'(cyc - e.hs_cyc), e.err ? 1 : 2);
              check("mem_ena_count", 64'(ena_cnt), e.err ? 0 : 1);
              if (e.is_lsu) begin
                check("lsu_err", lsu_resp_err, e.err);
                check("lsu_rdata", lsu_rdata, e.rdata);
              end else begin
                check("ifu_err", ifu_resp_err, e.err);
                check("ifu_rdata", 64'(ifu_rdata), e.rdata);
              end
              if (e.is_lsu && e.wen && !e.err)
                for (int i = 0; i < size_of(e.mask); i++)
                  model_mem[8'(e.addr[7:0] + 8'(i))] = e.wdata[8*i +: 8] ^ pat(8'(e.addr[7:0] + 8'(i)));
            end
            ena_cnt = 0;
          end
          if (ifu_req_valid && ifu_req_ready && lsu_req_valid && lsu_req_ready)
            check("ready_both", 1, 0);
          if (lsu_req_valid && lsu_req_ready) begin
            sz = size_of(lsu_mask);
            n.is_lsu = 1; n.addr = lsu_addr; n.mask = lsu_mask; n.wen = lsu_wen;
            n.wdata = lsu_wdata; n.hs_cyc = cyc;
            n.err = (sz == 0) || ((lsu_addr[2:0] & 3'(sz - 1)) != 3'b000);
            n.rdata = (n.err || lsu_wen) ? 64'h0 : model_rd(lsu_addr, sz);
            sb.push_back(n);
            grant_log.push_back(1'b1);
          end else if (ifu_req_valid && ifu_req_ready) begin
            n.is_lsu = 0; n.addr = ifu_addr; n.mask = 4'b0010; n.wen = 0;
            n.wdata = '0; n.hs_cyc = cyc;
            n.err = (ifu_addr[1:0] != 2'b00);
            n.rdata = n.err ? 64'h0 : model_rd(ifu_addr, 4);
            sb.push_back(n);
            grant_log.push_back(1'b0);
          end
        end
      end
      begin : stimulus
        #2 rst_n = 1'b0;
        #10;
        check_quiet("rst");
        check("rst_ifu_rdata", 64'(ifu_rdata), 0);
        check("rst_lsu_rdata", lsu_rdata, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Aligned fetch
        ifu_op(64'h8000_0004);
        drain();

        // Byte store then byte load at the same address
        lsu_op(1, 4'b1000, 64'h8000_0013, 64'h0000_0000_0000_00AB);
        lsu_op(0, 4'b1000, 64'h8000_0013, 64'h0);
        lsu_op(0, 4'b0001, 64'h8000_0010, 64'h0);
        // Dword store, then narrower loads from inside it
        lsu_op(1, 4'b0001, 64'h8000_0018, 64'h1122_3344_5566_7788);
        lsu_op(0, 4'b0010, 64'h8000_001C, 64'h0);
        lsu_op(0, 4'b0100, 64'h8000_001A, 64'h0);
        lsu_op(1, 4'b0100, 64'h8000_0022, 64'h0000_0000_0000_BEEF);
        lsu_op(0, 4'b0010, 64'h8000_0020, 64'h0);
        drain();

        // Illegal requests: misaligned half, non-one-hot mask store,
        // misaligned fetch, misaligned dword
        lsu_op(0, 4'b0100, 64'h8000_0001, 64'h0);
        lsu_op(1, 4'b0011, 64'h8000_0040, 64'hDEAD_BEEF_CAFE_F00D);
        lsu_op(0, 4'b0001, 64'h8000_0040, 64'h0);
        ifu_op(64'h8000_0002);
        lsu_op(1, 4'b0001, 64'h8000_0044, 64'hFFFF_FFFF_FFFF_FFFF);
        lsu_op(0, 4'b0001, 64'h8000_0040, 64'h0);
        drain();

        // Both requesters valid back to back
        grant_log.delete();
        fork
          for (int k = 0; k < 8; k++) lsu_op(0, 4'b0001, 64'h8000_0080 + 64'(8 * k), 64'h0);
          begin
            ifu_op(64'h8000_0090);
            ifu_op(64'h8000_0094);
          end
        join
        drain();
`ifdef MEM_ARB_RR_EN
        exp_order = 10'b1111111010;
`else
        exp_order = 10'b0111101111;
`endif
        check("grant_count", 64'(grant_log.size()), 10);
        for (int k = 0; k < 10 && k < grant_log.size(); k++)
          check($sformatf("grant_%0d", k), grant_log[k], exp_order[k]);

        // Reset during the ACCESS cycle of a store
        lsu_op(1, 4'b1000, 64'h8000_0030, 64'h0000_0000_0000_00CD);
        check("rst_pre_ena", mem_ena, 1);
        #1 rst_n = 1'b0;
        #1 check_quiet("rst_async");
        @(posedge clk); #1;
        check_quiet("rst_hold");
        check("rst_ready", {ifu_req_ready, lsu_req_ready}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        lsu_op(0, 4'b1000, 64'h8000_0030, 64'h0);
        lsu_op(0, 4'b0001, 64'h8000_0018, 64'h0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
      end
    join_any
  end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Two-requester arbiter and sequencer for the NPC's single shared data/instruction memory port.
- Requesters: instruction fetch (IFU, word reads only) and load/store unit (LSU, reads/writes of byte/half/word/double).
- Serialises accesses onto the memory port (ena/wen/mem_mask/addr/wdata, combinational rdata, write committed on posedge).
- Returns registered responses to the granted requester.

Parameters:
- AW, 64, address width.
- DW, 64, data width.
- STARVE_LIM, 4, consecutive LSU grants while IFU waits before IFU is forced (1..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ifu_req_valid  in  1  IFU request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  AW  fetch address
- ifu_resp_valid  out  1  one-cycle IFU response pulse
- ifu_resp_err  out  1  misaligned fetch
- ifu_rdata  out  32  instruction
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted
- lsu_wen  in  1  1 = store
- lsu_mask  in  4  one-hot size: bit0 dword, bit1 word, bit2 half, bit3 byte
- lsu_addr  in  AW  data address
- lsu_wdata  in  DW  store data
- lsu_resp_valid  out  1  one-cycle LSU response pulse
- lsu_resp_err  out  1  illegal mask or misaligned
- lsu_rdata  out  DW  load data, right-justified
- mem_ena, mem_wen  out  1  memory port enable / write enable
- mem_mask  out  4  memory size code
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data (combinational)

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low.
- Reset state:
  - FSM IDLE; starvation counter 0.
  - All resp_valid/err = 0; rdata regs = 0.
  - mem_* outputs = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Winner chosen combinationally; its req_ready = 1; the loser's req_ready = 0.
  - Handshake (valid & ready) latches addr, wen, mask, wdata and requester id; next state is ACCESS.
  - No valid: stay IDLE.
  - req_ready is 0 in ACCESS and RESP.
- Arbitration:
  - LSU wins over IFU by default.
  - The counter increments on each LSU grant while ifu_req_valid = 1.
  - When the counter equals STARVE_LIM and IFU is valid, IFU wins.
  - The counter clears on an IFU grant or whenever ifu_req_valid = 0.
- Legality check, done at latch time:
  - IFU: addr[1:0] must be 0.
  - LSU mask must be one-hot.
  - LSU alignment: dword needs addr[2:0] = 0; word needs addr[1:0] = 0; half needs addr[0] = 0.
  - An illegal request goes IDLE -> RESP directly; mem_ena stays 0, err = 1, rdata = 0, no write.
- ACCESS, exactly one cycle:
  - mem_ena = 1; mem_addr/mem_mask/mem_wdata come from the latched values.
  - mem_wen = latched wen; IFU always drives mem_wen = 0 and mem_mask = 4'b0010.
  - Posedge leaving ACCESS: the store commits in memory.
  - For reads, mem_rdata is captured: ifu_rdata = mem_rdata[31:0]; lsu_rdata = mem_rdata.
  - Stores return lsu_rdata = 0.
- RESP, one cycle:
  - The owning requester's resp_valid = 1; next state IDLE. There is no backpressure.
- Outside ACCESS, all mem_* outputs = 0.
- Latency: handshake at cycle N, memory access at N+1, resp_valid at N+2, next accept at N+3.
- Reset asserted mid-operation:
  - Immediate return to IDLE; mem_ena drops asynchronously, so no write commits.
  - Pending responses are discarded.
- Simultaneous IFU and LSU valid in IDLE: exactly one handshake; the loser's valid must be held.

Optional Feature:
- MEM_ARB_RR_EN defined: strict round-robin.
  - A 1-bit last-grant register (reset = IFU) is used.
  - On conflict, the requester not granted last time wins.
  - The starvation counter and STARVE_LIM are unused.
- Undefined: LSU priority with starvation limit, as above.

Test Plan:
- IFU only, addr 0x80000004 -> mem_ena high for exactly 1 cycle with mem_mask 4'b0010; ifu_resp_valid 2 cycles after handshake; ifu_rdata = word at that address.
- LSU store byte 0xAB at 0x80000013, then LSU load byte at the same address -> load response lsu_rdata = 0x00000000000000AB, err = 0.
- LSU load half at 0x80000001 -> mem_ena never asserted; lsu_resp_valid = 1, lsu_resp_err = 1, one cycle after handshake.
- LSU mask 4'b0011 -> same error response; memory is untouched.
- Both valid continuously, STARVE_LIM = 4 -> grant order LSU x4, IFU, LSU x4, IFU.
  - With MEM_ARB_RR_EN, the order instead alternates IFU, LSU, IFU, ...
- Store issued; rst_n pulsed low during ACCESS -> memory location unchanged, all outputs 0, FSM IDLE; the next request is accepted normally.
